prbs31_checker: RTL and testbench

Receive-side companion to the PRBS31 pattern generator (x^31 + x^28 + 1, serial MSB-out) on the TinyTapeout link-test top. It takes the serial bit stream coming back from the DUT or loopback path and self-synchronises a local PRBS31 predictor to it. Once locked, it counts bit errors and compared bits, giving a BER measurement. It declares loss of lock when errors become dense and re-hunts automatically.

---
 rtl/prbs31_checker.sv | 122 ++++++++++++
 tb/tb_prbs31_checker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker with BER counters
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active-high (legacy name kept for the link-test top)
//   din        received serial bit
//   din_valid  din is sampled only when high; low freezes all state
//   clr_cnt    synchronous clear of err_count and bit_count, wins over increments
//   locked     high while the local predictor is locked to the stream
//   err_pulse  one-cycle pulse after each errored bit accepted while locked
//   err_count  saturating count of errored bits while locked
//   bit_count  saturating count of bits compared while locked
module prbs31_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int LOSS_WINDOW = 128,
    parameter int LOSS_ERRS   = 8,
    parameter int ERR_W       = 16,
    parameter int BIT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(LOSS_WINDOW);
    localparam int EW = $clog2(LOSS_ERRS + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(LOSS_ERRS - 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [30:0]      sr_q, sr_d;
    logic [4:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [BIT_W-1:0] bit_count_q, bit_count_d;
    logic             p, err, match, win_end;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        p           = sr_q[27] ^ sr_q[30];
        err         = din != p;
        // an all-zero register predicts zeros forever, so it must never count as a match
        match       = fill_q == 5'd31 && sr_q != '0 && !err;
        win_end     = win_cnt_q == WIN_LAST;
        if (din_valid) begin
            if (state_q == HUNT) begin
                sr_d    = {sr_q[29:0], din};
                fill_d  = fill_q == 5'd31 ? fill_q : fill_q + 5'd1;
                match_d = match ? match_q + MW'(1) : '0;
                if (match && match_q == LOCK_LAST) begin
                    state_d   = LOCKED;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end
            end else begin
                // free-run on the prediction so received errors never pollute the predictor
                sr_d        = {sr_q[29:0], p};
                err_pulse_d = err;
                bit_count_d = bit_count_q == '1 ? bit_count_q : bit_count_q + BIT_W'(1);
                err_count_d = (err && err_count_q != '1) ? err_count_q + ERR_W'(1) : err_count_q;
                win_cnt_d   = win_end ? '0 : win_cnt_q + WW'(1);
                win_err_d   = win_end ? '0 : win_err_q + EW'(err);
                if (err && win_err_q == ERR_LAST) begin
                    state_d = HUNT;
                    fill_d  = '0;
                    match_d = '0;
                end
            end
        end
        if (clr_cnt) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = state_q == LOCKED;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: randomized and directed checks of prbs31_checker against a queue-based model
module tb_prbs31_checker;
    localparam int LOCK_COUNT  = 64;
    localparam int LOSS_WINDOW = 128;
    localparam int LOSS_ERRS   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [31:0] bit_count, bit_count4;
    logic [3:0]  err_count4;

    int n_checks = 0;
    int n_errors = 0;
    bit prbs [0:4095];

    int m_hist[$];
    int m_fill, m_run, m_win, m_werr, m_err, m_bits;
    bit m_locked, m_pulse;

    prbs31_checker dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    prbs31_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp16();
        return m_err > 65535 ? 16'hFFFF : 16'(m_err);
    endfunction

    function automatic logic [3:0] exp4();
        return m_err > 15 ? 4'hF : 4'(m_err);
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < 31; i++) m_hist.push_back(0);
        m_fill = 0; m_run = 0; m_win = 0; m_werr = 0; m_err = 0; m_bits = 0;
        m_locked = 0; m_pulse = 0;
    endtask

    // m_hist holds the last 31 register bits, oldest first: prediction = bit 31 back ^ bit 28 back
    task automatic model_step(input bit d, input bit v, input bit clr);
        int pred, ones;
        m_pulse = 0;
        if (v) begin
            pred = m_hist[0] ^ m_hist[3];
            ones = m_hist.sum();
            if (!m_locked) begin
                m_run = (m_fill == 31 && ones != 0 && int'(d) == pred) ? m_run + 1 : 0;
                m_fill = m_fill == 31 ? 31 : m_fill + 1;
                m_hist.push_back(int'(d));
                if (m_run == LOCK_COUNT) begin
                    m_locked = 1; m_win = 0; m_werr = 0;
                end
            end else begin
                m_bits++;
                m_win++;
                if (int'(d) != pred) begin
                    m_pulse = 1; m_err++; m_werr++;
                end
                if (m_pulse && m_werr >= LOSS_ERRS) begin
                    m_locked = 0; m_fill = 0; m_run = 0;
                end
                if (m_win == LOSS_WINDOW) begin
                    m_win = 0; m_werr = 0;
                end
                m_hist.push_back(pred);
            end
            void'(m_hist.pop_front());
        end
        if (clr) begin
            m_err = 0; m_bits = 0;
        end
    endtask

    task automatic drive(input bit d, input bit v, input bit clr);
        @(negedge clk);
        din = d; din_valid = v; clr_cnt = clr;
        @(posedge clk);
        model_step(d, v, clr);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            din = 1'($urandom); din_valid = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count} !== 50'd0) begin
                n_errors++;
                $display("FAIL reset[%0d] got l=%b p=%b e=%0d b=%0d want all zero", i, locked, err_pulse, err_count, bit_count);
            end
        end
        @(negedge clk);
        din_valid = 1'b0; rst_n = 1'b0;
        model_reset();
    endtask

    task automatic test_clean();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(prbs[i], 1'b1, 1'b0);
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count} !== {m_locked, m_pulse, exp16(), m_bits[31:0]}) begin
                n_errors++;
                $display("FAIL clean[%0d] got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d", i + 1, locked, err_pulse, err_count, bit_count, m_locked, m_pulse, exp16(), m_bits);
            end
            if (i + 1 == 94 || i + 1 == 95) begin
                n_checks++;
                if (locked !== (i + 1 == 95)) begin
                    n_errors++;
                    $display("FAIL clean_lock_edge bit %0d got locked=%b want %b", i + 1, locked, i + 1 == 95);
                end
            end
        end
        n_checks++;
        if (bit_count !== 32'd305 || err_count !== 16'd0) begin
            n_errors++;
            $display("FAIL clean_end got b=%0d e=%0d want b=305 e=0", bit_count, err_count);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(prbs[i] ^ (i == 299), 1'b1, 1'b0);
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count} !== {m_locked, m_pulse, exp16(), m_bits[31:0]}) begin
                n_errors++;
                $display("FAIL single[%0d] got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d", i + 1, locked, err_pulse, err_count, bit_count, m_locked, m_pulse, exp16(), m_bits);
            end
            if (i == 299 || i == 300) begin
                n_checks++;
                if (err_pulse !== (i == 299) || err_count !== 16'd1) begin
                    n_errors++;
                    $display("FAIL single_pulse bit %0d got p=%b e=%0d want p=%b e=1", i + 1, err_pulse, err_count, i == 299);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1 || err_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_end got l=%b e=%0d want l=1 e=1", locked, err_count);
        end
    endtask

    task automatic test_burst();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(prbs[i] ^ (i >= 99 && i <= 106), 1'b1, 1'b0);
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count} !== {m_locked, m_pulse, exp16(), m_bits[31:0]}) begin
                n_errors++;
                $display("FAIL burst[%0d] got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d", i + 1, locked, err_pulse, err_count, bit_count, m_locked, m_pulse, exp16(), m_bits);
            end
            if (i + 1 == 106 || i + 1 == 107 || i + 1 == 201 || i + 1 == 202) begin
                n_checks++;
                if (locked !== (i + 1 == 106 || i + 1 == 202)) begin
                    n_errors++;
                    $display("FAIL burst_lock bit %0d got locked=%b want %b", i + 1, locked, i + 1 == 106 || i + 1 == 202);
                end
            end
        end
        n_checks++;
        if (err_count !== 16'd8) begin
            n_errors++;
            $display("FAIL burst_errs got %0d want 8", err_count);
        end
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (locked !== 1'b0 || bit_count !== 32'd0) begin
                n_errors++;
                $display("FAIL zeros[%0d] got l=%b b=%0d want l=0 b=0", i + 1, locked, bit_count);
            end
        end
    endtask

    task automatic test_gapped_clear();
        int idx = 0;
        do_reset();
        for (int i = 0; i < 380; i++) begin
            bit v = (i % 2) == 0;
            drive(v ? prbs[idx] : 1'($urandom), v, 1'b0);
            if (v) idx++;
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count} !== {m_locked, m_pulse, exp16(), m_bits[31:0]}) begin
                n_errors++;
                $display("FAIL gapped[%0d] got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d", i, locked, err_pulse, err_count, bit_count, m_locked, m_pulse, exp16(), m_bits);
            end
            if (v && (idx == 94 || idx == 95)) begin
                n_checks++;
                if (locked !== (idx == 95)) begin
                    n_errors++;
                    $display("FAIL gapped_lock valid bit %0d got locked=%b want %b", idx, locked, idx == 95);
                end
            end
        end
        drive(~prbs[idx], 1'b1, 1'b1);
        idx++;
        n_checks++;
        if (err_pulse !== 1'b1 || err_count !== 16'd0 || bit_count !== 32'd0) begin
            n_errors++;
            $display("FAIL clear_with_error got p=%b e=%0d b=%0d want p=1 e=0 b=0", err_pulse, err_count, bit_count);
        end
        drive(prbs[idx], 1'b1, 1'b0);
        n_checks++;
        if (err_pulse !== 1'b0 || err_count !== 16'd0 || bit_count !== 32'd1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL after_clear got l=%b p=%b e=%0d b=%0d want l=1 p=0 e=0 b=1", locked, err_pulse, err_count, bit_count);
        end
    endtask

    task automatic test_saturate();
        int nerr = 0;
        do_reset();
        for (int i = 0; i < 895; i++) begin
            bit f = i >= 100 && (i - 100) % 40 == 0 && nerr < 20;
            if (f) nerr++;
            drive(prbs[i] ^ f, 1'b1, 1'b0);
            n_checks++;
            if ({locked4, err_pulse4, err_count4, bit_count4} !== {m_locked, m_pulse, exp4(), m_bits[31:0]}) begin
                n_errors++;
                $display("FAIL sat4[%0d] got l=%b p=%b e=%0d b=%0d want l=%b p=%b e=%0d b=%0d", i + 1, locked4, err_pulse4, err_count4, bit_count4, m_locked, m_pulse, exp4(), m_bits);
            end
        end
        n_checks++;
        if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_end got e4=%0d e=%0d l=%b want e4=15 e=20 l=1", err_count4, err_count, locked);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 120; i++) drive(prbs[i], 1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b1 || bit_count !== 32'd25) begin
            n_errors++;
            $display("FAIL async_pre got l=%b b=%0d want l=1 b=25", locked, bit_count);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_checks++;
        if ({locked, err_pulse, err_count, bit_count} !== 50'd0) begin
            n_errors++;
            $display("FAIL async_reset got l=%b p=%b e=%0d b=%0d want all zero", locked, err_pulse, err_count, bit_count);
        end
        @(negedge clk);
        din_valid = 1'b0; rst_n = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int idx = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit v = $urandom_range(0, 3) != 0;
            bit dense = (i / 600) % 3 == 2;
            bit f = dense ? $urandom_range(0, 2) == 0 : $urandom_range(0, 199) == 0;
            bit c = $urandom_range(0, 63) == 0;
            drive(v ? prbs[idx] ^ f : 1'($urandom), v, c);
            if (v) idx++;
            n_checks++;
            if ({locked, err_pulse, err_count, bit_count, err_count4} !== {m_locked, m_pulse, exp16(), m_bits[31:0], exp4()}) begin
                n_errors++;
                $display("FAIL random[%0d] got l=%b p=%b e=%0d b=%0d e4=%0d want l=%b p=%b e=%0d b=%0d e4=%0d", i, locked, err_pulse, err_count, bit_count, err_count4, m_locked, m_pulse, exp16(), m_bits, exp4());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 31; i++) prbs[i] = (i == 30);
        for (int i = 31; i < 4096; i++) prbs[i] = prbs[i - 31] ^ prbs[i - 28];
        model_reset();
        test_reset();
        test_clean();
        test_single_error();
        test_burst();
        test_zeros();
        test_gapped_clear();
        test_saturate();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
